// File: rtl/cory_arb_pkg.sv
// Shared types and helpers for the cory family of arbiters.
package cory_arb_pkg;

  localparam int GW = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_st_e;

  function automatic logic [GW-1:0] inc_mod4(input logic [GW-1:0] x);
    return x + 2'd1;
  endfunction

endpackage

// File: rtl/cory_rr_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod 4.
import cory_arb_pkg::*;

module cory_rr_pick4 (
  input  logic [3:0]    req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          win
);

  // Scan from the farthest candidate back to ptr so the closest one lands last.
  always_comb begin
    logic [GW-1:0] c;
    idx = '0;
    win = 1'b0;
    c   = '0;
    for (int i = 3; i >= 0; i--) begin
      c = ptr + GW'(i);
      if (req[c]) begin
        idx = c;
        win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cory_rrarb4.sv
// Four-input round-robin arbiter with optional packet lock and a registered output stage.
import cory_arb_pkg::*;

module cory_rrarb4 #(
  parameter int N    = 8,
  parameter bit LOCK = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a0_v,
  input  logic          i_a1_v,
  input  logic          i_a2_v,
  input  logic          i_a3_v,
  input  logic [N-1:0]  i_a0_d,
  input  logic [N-1:0]  i_a1_d,
  input  logic [N-1:0]  i_a2_d,
  input  logic [N-1:0]  i_a3_d,
  input  logic          i_a0_l,
  input  logic          i_a1_l,
  input  logic          i_a2_l,
  input  logic          i_a3_l,
  output logic          o_a0_r,
  output logic          o_a1_r,
  output logic          o_a2_r,
  output logic          o_a3_r,
  output logic          o_z_v,
  output logic [N-1:0]  o_z_d,
  output logic          o_z_l,
  output logic [GW-1:0] o_z_g,
  input  logic          i_z_r
);

  logic [3:0]        req_v, req_m, rdy;
  logic [3:0][N-1:0] req_d;
  logic [3:0]        req_l;
  logic [GW-1:0]     grant;
  logic              win, load, xfer;

  arb_st_e       st_q, st_d;
  logic [GW-1:0] ptr_q, ptr_d, own_q, own_d, z_g_q, z_g_d;
  logic          z_v_q, z_v_d, z_l_q, z_l_d;
  logic [N-1:0]  z_d_q, z_d_d;

  assign req_v = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign req_d = {i_a3_d, i_a2_d, i_a1_d, i_a0_d};
  assign req_l = {i_a3_l, i_a2_l, i_a1_l, i_a0_l};

  // While locked only the owner may compete.
  assign req_m = (st_q == ST_LOCKED) ? (req_v & (4'b0001 << own_q)) : req_v;

  cory_rr_pick4 u_pick (
    .req (req_m),
    .ptr (ptr_q),
    .idx (grant),
    .win (win)
  );

  assign load = !z_v_q || i_z_r;
  assign xfer = load && win;
  assign rdy  = xfer ? (4'b0001 << grant) : 4'b0000;

  assign {o_a3_r, o_a2_r, o_a1_r, o_a0_r} = rdy;
  assign o_z_v = z_v_q;
  assign o_z_d = z_d_q;
  assign o_z_l = z_l_q;
  assign o_z_g = z_g_q;

  always_comb begin
    z_v_d = z_v_q;
    z_d_d = z_d_q;
    z_l_d = z_l_q;
    z_g_d = z_g_q;
    st_d  = st_q;
    ptr_d = ptr_q;
    own_d = own_q;
    if (xfer) begin
      z_v_d = 1'b1;
      z_d_d = req_d[grant];
      z_l_d = req_l[grant];
      z_g_d = grant;
      if (st_q == ST_IDLE) begin
        if (LOCK && !req_l[grant]) begin
          st_d  = ST_LOCKED;
          own_d = grant;
        end else begin
          ptr_d = inc_mod4(grant);
        end
      end else if (req_l[grant]) begin
        st_d  = ST_IDLE;
        ptr_d = inc_mod4(own_q);
      end
    end else if (load) begin
      z_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_v_q <= 1'b0;
      z_d_q <= '0;
      z_l_q <= 1'b0;
      z_g_q <= '0;
      st_q  <= ST_IDLE;
      ptr_q <= '0;
      own_q <= '0;
    end else begin
      z_v_q <= z_v_d;
      z_d_q <= z_d_d;
      z_l_q <= z_l_d;
      z_g_q <= z_g_d;
      st_q  <= st_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
    end
  end

endmodule

// File: tb/tb_cory_rrarb4.sv
// Directed bench for cory_rrarb4: one locking and one non-locking instance on shared inputs.
module tb_cory_rrarb4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zr = 1'b1;
  logic [3:0] v, l;
  logic [7:0] d [4];

  logic [3:0] r, rn;
  logic       z_v, z_l, n_v, n_l;
  logic [7:0] z_d, n_d;
  logic [1:0] z_g, n_g;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cory_rrarb4 #(.N(8), .LOCK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_a0_v(v[0]), .i_a1_v(v[1]), .i_a2_v(v[2]), .i_a3_v(v[3]),
    .i_a0_d(d[0]), .i_a1_d(d[1]), .i_a2_d(d[2]), .i_a3_d(d[3]),
    .i_a0_l(l[0]), .i_a1_l(l[1]), .i_a2_l(l[2]), .i_a3_l(l[3]),
    .o_a0_r(r[0]), .o_a1_r(r[1]), .o_a2_r(r[2]), .o_a3_r(r[3]),
    .o_z_v(z_v), .o_z_d(z_d), .o_z_l(z_l), .o_z_g(z_g), .i_z_r(zr)
  );

  cory_rrarb4 #(.N(8), .LOCK(1'b0)) dut_nl (
    .clk(clk), .reset(reset),
    .i_a0_v(v[0]), .i_a1_v(v[1]), .i_a2_v(v[2]), .i_a3_v(v[3]),
    .i_a0_d(d[0]), .i_a1_d(d[1]), .i_a2_d(d[2]), .i_a3_d(d[3]),
    .i_a0_l(l[0]), .i_a1_l(l[1]), .i_a2_l(l[2]), .i_a3_l(l[3]),
    .o_a0_r(rn[0]), .o_a1_r(rn[1]), .o_a2_r(rn[2]), .o_a3_r(rn[3]),
    .o_z_v(n_v), .o_z_d(n_d), .o_z_l(n_l), .o_z_g(n_g), .i_z_r(zr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    v = '0;
    l = '0;
    for (int k = 0; k < 4; k++) d[k] = '0;
  endtask

  task automatic put(input int k, input logic vv, input logic [7:0] dd, input logic ll);
    v[k] = vv;
    d[k] = dd;
    l[k] = ll;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    zr = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    clr_in();

    // Reset state, then all four streaming single-beat packets.
    do_reset();
    chk("rst_v", z_v, 0);
    chk("rst_d", z_d, 0);
    chk("rst_l", z_l, 0);
    chk("rst_g", z_g, 0);
    for (int k = 0; k < 4; k++) put(k, 1'b1, 8'(k), 1'b1);
    #1;
    chk("rr_rdy0", r, 4'b0001);
    tick();
    for (int i = 1; i < 8; i++) begin
      chk("rr_v", z_v, 1);
      chk("rr_g", z_g, (i - 1) % 4);
      chk("rr_d", z_d, (i - 1) % 4);
      chk("rr_rdy", r, 4'b0001 << (i % 4));
      chk("rr_nl_g", n_g, (i - 1) % 4);
      tick();
    end

    // Locked 3-beat packet from a2 while others wait.
    do_reset();
    put(2, 1'b1, 8'h20, 1'b0);
    #1;
    chk("lk_rdy0", r, 4'b0100);
    tick();
    put(2, 1'b1, 8'h21, 1'b0);
    put(0, 1'b1, 8'h00, 1'b1);
    put(1, 1'b1, 8'h01, 1'b1);
    put(3, 1'b1, 8'h30, 1'b1);
    #1;
    chk("lk_rdy1", r, 4'b0100);
    chk("lk_d0", z_d, 8'h20);
    chk("lk_g0", z_g, 2);
    tick();
    put(2, 1'b1, 8'h22, 1'b1);
    #1;
    chk("lk_rdy2", r, 4'b0100);
    chk("lk_d1", z_d, 8'h21);
    chk("lk_g1", z_g, 2);
    tick();
    put(2, 1'b0, 8'h00, 1'b0);
    #1;
    chk("lk_rdy3", r, 4'b1000);
    chk("lk_d2", z_d, 8'h22);
    chk("lk_l2", z_l, 1);
    chk("lk_g2", z_g, 2);
    tick();
    chk("lk_after_g", z_g, 3);
    chk("lk_after_d", z_d, 8'h30);
    chk("lk_after_rdy", r, 4'b0001);

    // Downstream stall holds output and freezes arbitration.
    zr = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("st_rdy", r, 4'b0000);
      chk("st_d", z_d, 8'h30);
      chk("st_v", z_v, 1);
      tick();
    end
    zr = 1'b1;
    #1;
    chk("st_rel_rdy", r, 4'b0001);
    tick();
    chk("st_rel_g", z_g, 0);
    chk("st_rel_d", z_d, 8'h00);

    // Only a3 valid from ptr=0, then ptr must have wrapped to 0.
    do_reset();
    put(3, 1'b1, 8'h33, 1'b1);
    #1;
    chk("wr_rdy", r, 4'b1000);
    tick();
    chk("wr_g", z_g, 3);
    chk("wr_d", z_d, 8'h33);
    put(0, 1'b1, 8'h0A, 1'b1);
    #1;
    chk("wr_ptr0", r, 4'b0001);
    tick();
    chk("wr_g2", z_g, 0);

    // Non-locking instance alternates between a1 and a2 on l=0 beats.
    do_reset();
    put(1, 1'b1, 8'h11, 1'b0);
    put(2, 1'b1, 8'h22, 1'b0);
    #1;
    chk("nl_rdy0", rn, 4'b0010);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("nl_g", n_g, (i % 2 == 0) ? 1 : 2);
      chk("nl_d", n_d, (i % 2 == 0) ? 8'h11 : 8'h22);
      chk("nl_l", n_l, 0);
      tick();
    end

    // Async reset in the middle of a locked packet.
    do_reset();
    put(1, 1'b1, 8'h41, 1'b0);
    #1;
    chk("ar_rdy", r, 4'b0010);
    tick();
    chk("ar_v_pre", z_v, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_v_async", z_v, 0);
    chk("ar_d_async", z_d, 0);
    #1;
    reset = 1'b0;
    put(0, 1'b1, 8'h50, 1'b1);
    put(1, 1'b1, 8'h51, 1'b1);
    #1;
    chk("ar_idle_rdy", r, 4'b0001);
    @(posedge clk);
    #1;
    chk("ar_idle_g", z_g, 0);
    chk("ar_idle_d", z_d, 8'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
